// File: rtl/mem_request_ctrl_pkg.sv
// Shared types and helpers for the memory request front-end and its load extender.
// Purely declarative: no logic, no latency, no flow control of its own.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STROBE,
        ST_GAP,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [8:0] addr);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = (addr[1:0] != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_mask(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] m;
        case (size)
            SIZE_BYTE: m = {24'b0, wdata[7:0]};
            SIZE_HALF: m = {16'b0, wdata[15:0]};
            default:   m = wdata;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_request_ctrl_if.sv
// CPU-side request/response bundle: master is the control unit, slave is the controller.
// One request outstanding at a time; busy/done replace a ready handshake.
interface mem_request_ctrl_if;
    logic        mfa;
    logic        rw;
    logic [1:0]  size;
    logic        sign_ext;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        align_err;
    logic        tmo_err;

    modport master (
        output mfa, rw, size, sign_ext, addr, wdata,
        input  busy, done, rdata, align_err, tmo_err
    );

    modport slave (
        input  mfa, rw, size, sign_ext, addr, wdata,
        output busy, done, rdata, align_err, tmo_err
    );
endinterface

// File: rtl/mem_request_ctrl_ext.sv
// Load-data extender: byte/halfword sign or zero extension, word passthrough.
// Combinational, zero latency, no backpressure.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SIZE_BYTE: ext = {{24{sign_ext & raw[7]}}, raw[7:0]};
            SIZE_HALF: ext = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_request_ctrl.sv
// Single-outstanding RAM request sequencer: alignment check, clean Enable edge, MOC wait with timeout.
// Latency 5 cycles minimum (misaligned: 1); mfa is only sampled in IDLE, never queued.
module mem_request_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_request_ctrl_if.slave   cpu,
    output logic                ram_enable,
    output logic                ram_rw,
    output logic [8:0]          ram_addr,
    output logic [31:0]         ram_wdata,
    output logic [1:0]          ram_mode,
    input  logic                ram_moc,
    input  logic [31:0]         ram_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        moc_q;
    logic        req_sext;
    logic        busy_q;
    logic        done_q;
    logic        align_err_q;
    logic        tmo_err_q;
    logic [31:0] rdata_q;
    logic [31:0] ext_dat;

    mem_load_ext u_ext (
        .size     (ram_mode),
        .sign_ext (req_sext),
        .raw      (ram_rdata),
        .ext      (ext_dat)
    );

    assign cpu.busy      = busy_q;
    assign cpu.done      = done_q;
    assign cpu.rdata     = rdata_q;
    assign cpu.align_err = align_err_q;
    assign cpu.tmo_err   = tmo_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            moc_q       <= 1'b0;
            req_sext    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            rdata_q     <= '0;
            ram_enable  <= 1'b0;
            ram_rw      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_mode    <= '0;
        end else begin
            moc_q       <= ram_moc;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ram_enable <= 1'b0;
                    if (cpu.mfa) begin
                        busy_q   <= 1'b1;
                        req_sext <= cpu.sign_ext;
                        if (misaligned(cpu.size, cpu.addr)) begin
                            // Rejected requests never touch the RAM-facing registers.
                            state       <= ST_DONE;
                            done_q      <= 1'b1;
                            align_err_q <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            ram_rw    <= cpu.rw;
                            ram_addr  <= cpu.addr;
                            ram_mode  <= cpu.size;
                            ram_wdata <= store_mask(cpu.size, cpu.wdata);
                        end
                    end
                end
                ST_ISSUE: begin
                    ram_enable <= 1'b1;
                    state      <= ST_STROBE;
                end
                ST_STROBE: begin
                    cnt   <= '0;
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (moc_q) begin
                        if (ram_rw == RW_READ) begin
                            rdata_q <= ext_dat;
                        end
                        ram_enable <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= ST_DONE;
                    end else if (cnt == TMO_LAST) begin
                        ram_enable <= 1'b0;
                        done_q     <= 1'b1;
                        tmo_err_q  <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    ram_enable <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
